// File: rtl/fixed_pkg.sv
// Shared types and sizing helpers for the fixed-point arithmetic blocks.
// Combinational only: no latency.
// No flow control of its own: it only supplies types and sizing helpers.
package fixed_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Number of quotient bits produced for a Q(total-frac).frac divide.
  function automatic int quot_bits(input int total, input int frac);
    return total + frac;
  endfunction

  // Width of a down-counter that must hold n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/divu_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
// Latency: combinational.
// No flow control; the caller sequences the steps.
module divu_step #(
  parameter int W = 7
) (
  input  logic [W:0]   rem,
  input  logic         dbit,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_next,
  output logic         qbit
);

  logic [W+1:0] shifted;
  logic [W+1:0] div_ext;

  // The partial remainder is always below the divisor, so the shifted value and
  // the difference both fit back into W+1 bits; the top bit only feeds the compare.
  always_comb begin
    shifted  = {rem, dbit};
    div_ext  = {2'b00, divisor};
    qbit     = (shifted >= div_ext);
    rem_next = (W+1)'(qbit ? (shifted - div_ext) : shifted);
  end

endmodule

// File: rtl/divu_seq.sv
// Iterative unsigned fixed-point divider, out = in1 / in2 in the operand Q format.
// Latency: TOTAL_BITS+FRACTIONAL_BITS edges after accept; a zero divisor finishes on the accept edge.
// Backpressure: one operation in flight; result held in DONE until out_ready, in_ready low meanwhile.
module divu_seq
  import fixed_pkg::*;
#(
  parameter int TOTAL_BITS      = 7,
  parameter int FRACTIONAL_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [TOTAL_BITS-1:0] in1,
  input  logic [TOTAL_BITS-1:0] in2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TOTAL_BITS-1:0] out,
  output logic                  overflow,
  output logic                  div_by_zero
);

  localparam int N  = quot_bits(TOTAL_BITS, FRACTIONAL_BITS);
  localparam int CW = cnt_width(N);
  // Largest quotient representable in the output format.
  localparam logic [N-1:0] QMAX = N'({TOTAL_BITS{1'b1}});

  div_state_t            state;
  div_state_t            state_nxt;
  logic [CW-1:0]         cnt;
  logic [N-1:0]          dvd;
  logic [TOTAL_BITS-1:0] dvs;
  logic [TOTAL_BITS:0]   rem;
  logic [N-1:0]          quo;
  logic [TOTAL_BITS:0]   step_rem;
  logic                  step_q;
  logic [N-1:0]          quo_nxt;
  logic                  quo_ovf;

  divu_step #(.W(TOTAL_BITS)) u_step (
    .rem      (rem),
    .dbit     (dvd[N-1]),
    .divisor  (dvs),
    .rem_next (step_rem),
    .qbit     (step_q)
  );

  // Quotient after the current step, and whether it exceeds the output range.
  always_comb begin
    quo_nxt = N'({quo, step_q});
    quo_ovf = (quo_nxt > QMAX);
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: a zero divisor skips the iteration entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = (in2 == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath: latch operands on accept, one restoring step per RUN cycle,
  // publish the saturated result on the last step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      quo         <= '0;
      out         <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd         <= N'(in1) << FRACTIONAL_BITS;
            dvs         <= in2;
            rem         <= '0;
            quo         <= '0;
            cnt         <= CW'(N - 1);
            overflow    <= 1'b0;
            div_by_zero <= (in2 == '0);
            out         <= (in2 == '0) ? '1 : '0;
          end
        end
        RUN: begin
          dvd <= dvd << 1;
          rem <= step_rem;
          quo <= quo_nxt;
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            overflow <= quo_ovf;
            out      <= quo_ovf ? '1 : quo_nxt[TOTAL_BITS-1:0];
          end
        end
        default: begin
          // DONE holds every register until the result handshake.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divu_seq.sv
// Self-checking bench for divu_seq: a Q4.3 instance and an integer (Q7.0) instance
// driven with directed and random operands, compared against an arithmetic model.
// Both instances share clock and reset.
module tb_divu_seq;

  logic       clk;
  logic       reset_n;

  logic       q_in_valid, q_in_ready, q_out_valid, q_out_ready, q_ovf, q_dbz;
  logic [6:0] q_in1, q_in2, q_out;
  logic       i_in_valid, i_in_ready, i_out_valid, i_out_ready, i_ovf, i_dbz;
  logic [6:0] i_in1, i_in2, i_out;

  int nchecks = 0;
  int nerrors = 0;

  divu_seq #(.TOTAL_BITS(7), .FRACTIONAL_BITS(3)) dut_q (
    .clk(clk), .reset_n(reset_n),
    .in_valid(q_in_valid), .in_ready(q_in_ready), .in1(q_in1), .in2(q_in2),
    .out_valid(q_out_valid), .out_ready(q_out_ready), .out(q_out),
    .overflow(q_ovf), .div_by_zero(q_dbz)
  );

  divu_seq #(.TOTAL_BITS(7), .FRACTIONAL_BITS(0)) dut_i (
    .clk(clk), .reset_n(reset_n),
    .in_valid(i_in_valid), .in_ready(i_in_ready), .in1(i_in1), .in2(i_in2),
    .out_valid(i_out_valid), .out_ready(i_out_ready), .out(i_out),
    .overflow(i_ovf), .div_by_zero(i_dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {div_by_zero, overflow, out} from plain integer arithmetic.
  function automatic logic [8:0] model(input int a, input int b, input int frac);
    int q;
    if (b == 0) return {1'b1, 1'b0, 7'h7F};
    q = (a << frac) / b;
    if (q > 127) return {1'b0, 1'b1, 7'h7F};
    return {2'b00, 7'(q)};
  endfunction

  // Drive one operation into the Q4.3 instance and wait (bounded) for its result.
  // lat counts edges after the accepting edge until out_valid is seen.
  task automatic q_op(input logic [6:0] a, input logic [6:0] b,
                      output logic [6:0] o, output logic ov, output logic dz,
                      output int lat, output bit to);
    @(negedge clk);
    q_in1 = a; q_in2 = b; q_in_valid = 1'b1;
    @(posedge clk);
    #1;
    q_in_valid = 1'b0;
    q_in1 = 7'($urandom); q_in2 = 7'($urandom);
    lat = 0; to = 1'b0;
    while (!q_out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    if (!q_out_valid) to = 1'b1;
    o = q_out; ov = q_ovf; dz = q_dbz;
  endtask

  task automatic i_op(input logic [6:0] a, input logic [6:0] b,
                      output logic [6:0] o, output logic ov, output logic dz,
                      output int lat, output bit to);
    @(negedge clk);
    i_in1 = a; i_in2 = b; i_in_valid = 1'b1;
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    i_in1 = 7'($urandom); i_in2 = 7'($urandom);
    lat = 0; to = 1'b0;
    while (!i_out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    if (!i_out_valid) to = 1'b1;
    o = i_out; ov = i_ovf; dz = i_dbz;
  endtask

  // Complete the output handshake on the Q4.3 instance.
  task automatic q_release();
    @(negedge clk); q_out_ready = 1'b1;
    @(posedge clk); #1; q_out_ready = 1'b0;
  endtask

  task automatic i_release();
    @(negedge clk); i_out_ready = 1'b1;
    @(posedge clk); #1; i_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    nchecks++; if (q_in_ready !== 1'b1) begin nerrors++; $display("FAIL reset_in_ready got=%b exp=1", q_in_ready); end
    nchecks++; if (q_out_valid !== 1'b0) begin nerrors++; $display("FAIL reset_out_valid got=%b exp=0", q_out_valid); end
    nchecks++; if (q_out !== 7'h00) begin nerrors++; $display("FAIL reset_out got=%h exp=00", q_out); end
    nchecks++; if ({q_ovf, q_dbz} !== 2'b00) begin nerrors++; $display("FAIL reset_flags got=%b exp=00", {q_ovf, q_dbz}); end
    nchecks++; if ({i_in_ready, i_out_valid} !== 2'b10) begin nerrors++; $display("FAIL reset_int_hs got=%b exp=10", {i_in_ready, i_out_valid}); end
  endtask

  task automatic test_basic();
    logic [6:0] o; logic ov, dz; int lat; bit to;
    // 3.0 / 2.0 = 1.5
    q_op(7'b0011_000, 7'b0010_000, o, ov, dz, lat, to);
    nchecks++; if (to) begin nerrors++; $display("FAIL basic_timeout got=no out_valid exp=out_valid"); end
    nchecks++; if (o !== 7'b0001_100) begin nerrors++; $display("FAIL basic_out got=%b exp=0001100", o); end
    nchecks++; if ({ov, dz} !== 2'b00) begin nerrors++; $display("FAIL basic_flags got=%b exp=00", {ov, dz}); end
    nchecks++; if (lat != 10) begin nerrors++; $display("FAIL basic_latency got=%0d exp=10", lat); end
    q_release();
    nchecks++; if ({q_in_ready, q_out_valid} !== 2'b10) begin nerrors++; $display("FAIL basic_post_hs got=%b exp=10", {q_in_ready, q_out_valid}); end
    // 1.0 / 3.0 = 0.25 after truncation
    q_op(7'b0001_000, 7'b0011_000, o, ov, dz, lat, to);
    nchecks++; if (o !== 7'b0000_010 || to) begin nerrors++; $display("FAIL trunc_out got=%b exp=0000010", o); end
    q_release();
    // 15.0 / 2.0 = 7.5
    q_op(7'b1111_000, 7'b0010_000, o, ov, dz, lat, to);
    nchecks++; if ({o, ov} !== {7'b0111_100, 1'b0} || to) begin nerrors++; $display("FAIL half_out got=%b/%b exp=0111100/0", o, ov); end
    q_release();
  endtask

  task automatic test_overflow();
    logic [6:0] o; logic ov, dz; int lat; bit to;
    // 15.0 / 0.25 = 60 does not fit Q4.3
    q_op(7'b1111_000, 7'b0000_010, o, ov, dz, lat, to);
    nchecks++; if ({o, ov, dz} !== {7'h7F, 2'b10} || to) begin nerrors++; $display("FAIL ovf_quarter got=%b/%b%b exp=1111111/10", o, ov, dz); end
    q_release();
    // 15.0 / 0.5 = 30 does not fit either
    q_op(7'b1111_000, 7'b0000_100, o, ov, dz, lat, to);
    nchecks++; if ({o, ov, dz} !== {7'h7F, 2'b10} || lat != 10) begin nerrors++; $display("FAIL ovf_half got=%b/%b%b lat=%0d exp=1111111/10 lat=10", o, ov, dz, lat); end
    q_release();
  endtask

  task automatic test_div_zero();
    logic [6:0] o; logic ov, dz; int lat; bit to;
    q_op(7'b0101_000, 7'b0000_000, o, ov, dz, lat, to);
    nchecks++; if (lat != 0) begin nerrors++; $display("FAIL dbz_latency got=%0d exp=0 edges beyond accept", lat); end
    nchecks++; if ({o, ov, dz} !== {7'h7F, 2'b01}) begin nerrors++; $display("FAIL dbz_result got=%b/%b%b exp=1111111/01", o, ov, dz); end
    q_release();
    // flags must clear on the next accept
    q_op(7'b0011_000, 7'b0010_000, o, ov, dz, lat, to);
    nchecks++; if ({o, ov, dz} !== {7'b0001_100, 2'b00}) begin nerrors++; $display("FAIL dbz_flag_clear got=%b/%b%b exp=0001100/00", o, ov, dz); end
    q_release();
  endtask

  task automatic test_random();
    logic [6:0] o, a, b; logic ov, dz; int lat; bit to; logic [8:0] exp;
    for (int k = 0; k < 24; k++) begin
      a = 7'($urandom);
      b = (k % 8 == 3) ? 7'd0 : 7'($urandom_range(127, 0));
      exp = model(int'(a), int'(b), 3);
      q_op(a, b, o, ov, dz, lat, to);
      nchecks++;
      if ({dz, ov, o} !== exp || to || lat != ((b == 0) ? 0 : 10)) begin
        nerrors++;
        $display("FAIL rand_q a=%h b=%h got=%b lat=%0d exp=%b lat=%0d", a, b, {dz, ov, o}, lat, exp, (b == 0) ? 0 : 10);
      end
      q_release();
    end
    for (int k = 0; k < 8; k++) begin
      a = 7'($urandom);
      b = 7'($urandom_range(127, 1));
      exp = model(int'(a), int'(b), 0);
      i_op(a, b, o, ov, dz, lat, to);
      nchecks++;
      if ({dz, ov, o} !== exp || to || lat != 7) begin
        nerrors++;
        $display("FAIL rand_int a=%h b=%h got=%b lat=%0d exp=%b lat=7", a, b, {dz, ov, o}, lat, exp);
      end
      i_release();
    end
  endtask

  task automatic test_backpressure();
    logic [6:0] o; logic ov, dz; int lat; bit to; int bad;
    q_op(7'b0001_000, 7'b0011_000, o, ov, dz, lat, to);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      q_in_valid = (c % 2 == 0);
      q_in1 = 7'($urandom); q_in2 = 7'($urandom);
      @(posedge clk); #1;
      if ({q_out_valid, q_in_ready, q_out, q_ovf, q_dbz} !== {2'b10, 7'b0000_010, 2'b00}) bad++;
    end
    q_in_valid = 1'b0;
    nchecks++; if (bad != 0) begin nerrors++; $display("FAIL bp_hold got=%0d unstable cycles exp=0", bad); end
    q_release();
    nchecks++; if ({q_in_ready, q_out_valid} !== 2'b10) begin nerrors++; $display("FAIL bp_release got=%b exp=10", {q_in_ready, q_out_valid}); end
    q_op(7'b0011_000, 7'b0010_000, o, ov, dz, lat, to);
    nchecks++; if (o !== 7'b0001_100 || lat != 10) begin nerrors++; $display("FAIL bp_next_op got=%b lat=%0d exp=0001100 lat=10", o, lat); end
    q_release();
  endtask

  task automatic test_reset_abort();
    logic [6:0] o; logic ov, dz; int lat; bit to; int seen;
    @(negedge clk);
    q_in1 = 7'b0111_000; q_in2 = 7'b0010_000; q_in_valid = 1'b1;
    @(posedge clk); #1; q_in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    nchecks++; if ({q_out_valid, q_in_ready} !== 2'b01) begin nerrors++; $display("FAIL abort_hs got=%b exp=01", {q_out_valid, q_in_ready}); end
    nchecks++; if ({q_out, q_ovf, q_dbz} !== 9'd0) begin nerrors++; $display("FAIL abort_outputs got=%b exp=0", {q_out, q_ovf, q_dbz}); end
    @(negedge clk); reset_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (q_out_valid) seen++;
    end
    nchecks++; if (seen != 0) begin nerrors++; $display("FAIL abort_no_result got=%0d valid cycles exp=0", seen); end
    i_op(7'd6, 7'd3, o, ov, dz, lat, to);
    nchecks++; if ({o, ov, dz} !== {7'd2, 2'b00} || lat != 7 || to) begin nerrors++; $display("FAIL int_6_3 got=%0d/%b%b lat=%0d exp=2/00 lat=7", o, ov, dz, lat); end
    i_release();
  endtask

  initial begin
    reset_n = 1'b0;
    q_in_valid = 1'b0; q_out_ready = 1'b0; q_in1 = '0; q_in2 = '0;
    i_in_valid = 1'b0; i_out_ready = 1'b0; i_in1 = '0; i_in2 = '0;
    #23;
    test_reset();
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_overflow();
    test_div_zero();
    test_backpressure();
    test_random();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
